servant_spi_line_buf: RTL and testbench



---
 rtl/servant_spi_line_buf.sv | 184 ++++++++++++++++++
 tb/tb_servant_spi_line_buf.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_spi_line_buf.sv
// servant_spi_line_buf: single-line read buffer between the servile CPU Wishbone port and the SPI master.
//
// Read misses fill one aligned line of LINE_WORDS words with sequential SPI word
// reads (one idle cycle between words). Reads that hit the line are answered in
// one cycle with no SPI traffic. Writes always pass through to SPI memory.
//
// Optional feature macro: SPI_LINE_BUF_WRITE_UPDATE_EN
//   defined   : a write hit merges its enabled byte lanes into the buffered word
//   undefined : a write hit invalidates the buffered line
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_cpu_adr/dat/sel/we/cyc  CPU request (word address, write data, byte enables)
//   o_cpu_rdt, o_cpu_ack      CPU read data and single-cycle acknowledge
//   o_mem_adr/dat/sel/we/cyc  request to the SPI master
//   i_mem_rdt, i_mem_ack      SPI master read data and acknowledge
module servant_spi_line_buf #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int LINE_WORDS    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [ADDRESS_WIDTH-3:0] i_cpu_adr,
    input  logic [31:0]              i_cpu_dat,
    input  logic [3:0]               i_cpu_sel,
    input  logic                     i_cpu_we,
    input  logic                     i_cpu_cyc,
    output logic [31:0]              o_cpu_rdt,
    output logic                     o_cpu_ack,
    output logic [ADDRESS_WIDTH-3:0] o_mem_adr,
    output logic [31:0]              o_mem_dat,
    output logic [3:0]               o_mem_sel,
    output logic                     o_mem_we,
    output logic                     o_mem_cyc,
    input  logic [31:0]              i_mem_rdt,
    input  logic                     i_mem_ack
);
    localparam int AW = ADDRESS_WIDTH - 2;
    localparam int LW = $clog2(LINE_WORDS);
    localparam int TW = AW - LW;

    typedef enum logic [2:0] {IDLE, FILL, GAP, WR, RESP, ACKW} state_t;

    state_t          state_q;
    logic [31:0]     buf_q [LINE_WORDS];
    logic [TW-1:0]   tag_q;
    logic            valid_q;
    logic [LW-1:0]   cnt_q;
    logic [31:0]     cpu_rdt_q;
    logic            cpu_ack_q;
    logic [AW-1:0]   mem_adr_q;
    logic [31:0]     mem_dat_q;
    logic [3:0]      mem_sel_q;
    logic            mem_we_q;
    logic            mem_cyc_q;

    logic [TW-1:0]   cpu_tag;
    logic [LW-1:0]   cpu_idx;
    logic            hit;
    logic            last;
    logic [31:0]     fill_word_d;
    logic [31:0]     wr_merge_d;
    logic            wr_upd;
    logic            wr_inv;

    assign cpu_tag = i_cpu_adr[AW-1:LW];
    assign cpu_idx = i_cpu_adr[LW-1:0];
    assign hit     = valid_q && (tag_q == cpu_tag);
    assign last    = cnt_q == LW'(LINE_WORDS - 1);

    // The last fill word lands in buf_q on the same edge the response is
    // registered, so forward it directly when it is the requested word.
    assign fill_word_d = (cpu_idx == cnt_q) ? i_mem_rdt : buf_q[cpu_idx];

    always_comb begin
        wr_merge_d = buf_q[cpu_idx];
        for (int b = 0; b < 4; b++)
            if (i_cpu_sel[b]) wr_merge_d[8*b +: 8] = i_cpu_dat[8*b +: 8];
    end

`ifdef SPI_LINE_BUF_WRITE_UPDATE_EN
    assign wr_upd = hit;
    assign wr_inv = 1'b0;
`else
    assign wr_upd = 1'b0;
    assign wr_inv = hit;
`endif

    // Line storage is deliberately not reset; valid_q guards it.
    always_ff @(posedge i_clk) begin
        if (state_q == FILL && i_mem_ack)
            buf_q[cnt_q] <= i_mem_rdt;
        else if (state_q == WR && i_mem_ack && wr_upd)
            buf_q[cpu_idx] <= wr_merge_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            cpu_rdt_q <= '0;
            cpu_ack_q <= 1'b0;
            mem_adr_q <= '0;
            mem_dat_q <= '0;
            mem_sel_q <= '0;
            mem_we_q  <= 1'b0;
            mem_cyc_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_cpu_cyc && !cpu_ack_q) begin
                        if (i_cpu_we) begin
                            state_q   <= WR;
                            mem_cyc_q <= 1'b1;
                            mem_we_q  <= 1'b1;
                            mem_adr_q <= i_cpu_adr;
                            mem_dat_q <= i_cpu_dat;
                            mem_sel_q <= i_cpu_sel;
                        end else if (hit) begin
                            state_q   <= RESP;
                            cpu_ack_q <= 1'b1;
                            cpu_rdt_q <= buf_q[cpu_idx];
                        end else begin
                            state_q   <= FILL;
                            valid_q   <= 1'b0;
                            tag_q     <= cpu_tag;
                            cnt_q     <= '0;
                            mem_cyc_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                            mem_adr_q <= {cpu_tag, LW'(0)};
                            mem_dat_q <= '0;
                            mem_sel_q <= 4'hF;
                        end
                    end
                end
                FILL: begin
                    if (i_mem_ack) begin
                        mem_cyc_q <= 1'b0;
                        if (last) begin
                            state_q   <= RESP;
                            valid_q   <= 1'b1;
                            cpu_ack_q <= 1'b1;
                            cpu_rdt_q <= fill_word_d;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    state_q   <= FILL;
                    cnt_q     <= cnt_q + LW'(1);
                    mem_cyc_q <= 1'b1;
                    mem_adr_q <= {tag_q, cnt_q + LW'(1)};
                end
                WR: begin
                    if (i_mem_ack) begin
                        state_q   <= ACKW;
                        mem_cyc_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        cpu_ack_q <= 1'b1;
                        cpu_rdt_q <= '0;
                        if (wr_inv) valid_q <= 1'b0;
                    end
                end
                RESP, ACKW: begin
                    state_q   <= IDLE;
                    cpu_ack_q <= 1'b0;
                    cpu_rdt_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_cpu_rdt = cpu_rdt_q;
    assign o_cpu_ack = cpu_ack_q;
    assign o_mem_adr = mem_adr_q;
    assign o_mem_dat = mem_dat_q;
    assign o_mem_sel = mem_sel_q;
    assign o_mem_we  = mem_we_q;
    assign o_mem_cyc = mem_cyc_q;
endmodule

// File: tb/tb_servant_spi_line_buf.sv
// tb_servant_spi_line_buf: randomized self-checking bench for servant_spi_line_buf against a line-level reference model.
module tb_servant_spi_line_buf;
    localparam int AW   = 22;
    localparam int LINE = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] i_cpu_adr;
    logic [31:0]   i_cpu_dat;
    logic [3:0]    i_cpu_sel;
    logic          i_cpu_we;
    logic          i_cpu_cyc;
    logic [31:0]   o_cpu_rdt;
    logic          o_cpu_ack;
    logic [AW-1:0] o_mem_adr;
    logic [31:0]   o_mem_dat;
    logic [3:0]    o_mem_sel;
    logic          o_mem_we;
    logic          o_mem_cyc;
    logic [31:0]   i_mem_rdt;
    logic          i_mem_ack;

    servant_spi_line_buf dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_cpu_adr (i_cpu_adr),
        .i_cpu_dat (i_cpu_dat),
        .i_cpu_sel (i_cpu_sel),
        .i_cpu_we  (i_cpu_we),
        .i_cpu_cyc (i_cpu_cyc),
        .o_cpu_rdt (o_cpu_rdt),
        .o_cpu_ack (o_cpu_ack),
        .o_mem_adr (o_mem_adr),
        .o_mem_dat (o_mem_dat),
        .o_mem_sel (o_mem_sel),
        .o_mem_we  (o_mem_we),
        .o_mem_cyc (o_mem_cyc),
        .i_mem_rdt (i_mem_rdt),
        .i_mem_ack (i_mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int now();
        return int'($time / 10);
    endfunction

    // SPI memory contents
    logic [31:0] mem [int];

    function automatic logic [31:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    task automatic mem_wr(input int a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        v = mem_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        mem[a] = v;
    endtask

    // SPI slave model with per-transaction latency and transaction logs
    int lat = 20;
    int lc;
    int rd_adr [$];
    int rd_ack [$];
    int rd_rise [$];
    int wr_cnt, wr_t;
    logic [31:0] wr_adr, wr_dat;
    logic [3:0]  wr_sel;

    task automatic clear_logs();
        rd_adr.delete();
        rd_ack.delete();
        rd_rise.delete();
        wr_cnt = 0;
    endtask

    initial begin
        i_mem_ack = 1'b0;
        i_mem_rdt = '0;
        lc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                i_mem_ack = 1'b0;
                lc = 0;
            end else if (i_mem_ack) begin
                i_mem_ack = 1'b0;
                i_mem_rdt = '0;
                lc = 0;
            end else if (o_mem_cyc) begin
                if (lc == 0 && !o_mem_we) rd_rise.push_back(now());
                lc++;
                if (lc >= lat) begin
                    i_mem_ack = 1'b1;
                    if (o_mem_we) begin
                        mem_wr(int'(o_mem_adr), o_mem_dat, o_mem_sel);
                        wr_adr = 32'(o_mem_adr);
                        wr_dat = o_mem_dat;
                        wr_sel = o_mem_sel;
                        wr_t   = now();
                        wr_cnt++;
                    end else begin
                        i_mem_rdt = mem_rd(int'(o_mem_adr));
                        rd_adr.push_back(int'(o_mem_adr));
                        rd_ack.push_back(now());
                    end
                end
            end
        end
    end

    // Reference line state: whole-line granularity
    bit ref_valid = 0;
    int ref_line  = 0;

    task automatic do_read(input int a);
        bit exp_hit, got;
        int t0, t1, n;
        logic [31:0] d;
        exp_hit = ref_valid && (a / LINE) == ref_line;
        clear_logs();
        @(negedge clk);
        i_cpu_cyc = 1'b1;
        i_cpu_we  = 1'b0;
        i_cpu_adr = AW'(a);
        i_cpu_sel = 4'($urandom);
        t0 = now();
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = o_cpu_ack;
        end
        t1 = now();
        d  = o_cpu_rdt;
        i_cpu_cyc = 1'b0;
        check("rd_ack", 32'(got), 1);
        check("rd_data", d, mem_rd(a));
        n = rd_adr.size();
        check("rd_nmem", n, exp_hit ? 0 : LINE);
        check("rd_nowr", wr_cnt, 0);
        if (exp_hit) check("hit_lat", t1 - t0, 1);
        else if (n == LINE) begin
            check("fill_start", rd_rise[0], t0 + 1);
            for (int i = 0; i < LINE; i++) check("fill_adr", rd_adr[i], (a / LINE) * LINE + i);
            for (int i = 1; i < LINE; i++) check("fill_gap", rd_rise[i] - rd_ack[i-1], 2);
            check("miss_ack_lat", t1, rd_ack[LINE-1] + 1);
        end
        if (!exp_hit) begin
            ref_valid = 1;
            ref_line  = a / LINE;
        end
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] s);
        bit exp_hit, got;
        int t1;
        logic [31:0] r;
        exp_hit = ref_valid && (a / LINE) == ref_line;
        clear_logs();
        @(negedge clk);
        i_cpu_cyc = 1'b1;
        i_cpu_we  = 1'b1;
        i_cpu_adr = AW'(a);
        i_cpu_dat = d;
        i_cpu_sel = s;
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = o_cpu_ack;
        end
        t1 = now();
        r  = o_cpu_rdt;
        i_cpu_cyc = 1'b0;
        i_cpu_we  = 1'b0;
        check("wr_ack", 32'(got), 1);
        check("wr_rdt", r, 0);
        check("wr_cnt", wr_cnt, 1);
        check("wr_adr", wr_adr, a);
        check("wr_dat", wr_dat, d);
        check("wr_sel", 32'(wr_sel), 32'(s));
        check("wr_ack_lat", t1, wr_t + 1);
        check("wr_noread", rd_adr.size(), 0);
`ifndef SPI_LINE_BUF_WRITE_UPDATE_EN
        if (exp_hit) ref_valid = 0;
`endif
    endtask

    initial begin
        bit ok;
        int t0, last, nack;
        rst_n     = 1'b0;
        i_cpu_cyc = 1'b0;
        i_cpu_we  = 1'b0;
        i_cpu_adr = '0;
        i_cpu_dat = '0;
        i_cpu_sel = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ack", 32'(o_cpu_ack), 0);
        check("rst_rdt", o_cpu_rdt, 0);
        check("rst_cyc", 32'(o_mem_cyc), 0);
        check("rst_we", 32'(o_mem_we), 0);
        check("rst_adr", 32'(o_mem_adr), 0);
        check("rst_sel", 32'(o_mem_sel), 0);
        check("rst_dat", o_mem_dat, 0);

        lat = 20;
        do_read('h10);
        do_read('h12);
        do_read('h13);
        do_read('h14);
        do_read('h11);

        lat = 3;
        do_write('h12, 32'hA5A5A5A5, 4'b0011);
        do_read('h12);
        check("merge_low", mem_rd('h12) & 32'hFFFF, 32'hA5A5);

        // back-to-back hits with the request held high
        clear_logs();
        @(negedge clk);
        i_cpu_cyc = 1'b1;
        i_cpu_we  = 1'b0;
        i_cpu_adr = AW'('h10);
        t0 = now();
        last = -1;
        nack = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_cpu_ack) begin
                check("b2b_data", o_cpu_rdt, mem_rd(int'(i_cpu_adr)));
                check("b2b_time", now() - t0, 2 * nack + 1);
                if (last >= 0) check("b2b_spacing", now() - last, 2);
                last = now();
                nack++;
                i_cpu_adr = (i_cpu_adr == AW'('h10)) ? AW'('h11) : AW'('h10);
            end
        end
        i_cpu_cyc = 1'b0;
        check("b2b_acks", nack, 6);
        check("b2b_nomem", rd_adr.size(), 0);

        // reset in the middle of the second fill word
        lat = 5;
        do_read('h20);
        clear_logs();
        @(negedge clk);
        i_cpu_cyc = 1'b1;
        i_cpu_we  = 1'b0;
        i_cpu_adr = AW'('h10);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = rd_adr.size() == 1;
        end
        check("rst_wait", 32'(ok), 1);
        repeat (2) @(negedge clk);
        check("pre_rst_cyc", 32'(o_mem_cyc), 1);
        rst_n = 1'b0;
        #1;
        check("midfill_rst_cyc", 32'(o_mem_cyc), 0);
        check("midfill_rst_ack", 32'(o_cpu_ack), 0);
        i_cpu_cyc = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_valid = 0;
        do_read('h10);
        do_read('h13);

        // randomized mix
        for (int i = 0; i < 80; i++) begin
            lat = int'($urandom_range(1, 6));
            if ($urandom_range(0, 9) < 3)
                do_write(int'($urandom_range(0, 31)), $urandom, 4'($urandom_range(1, 15)));
            else
                do_read(int'($urandom_range(0, 31)));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
